// File: rtl/fleet_pkg.sv
// fleet_pkg: shared state encoding, edge-code bit positions and period width for the fleet mover blocks.
package fleet_pkg;
    localparam int PERIOD_W = 6;
    localparam int EDGE_LEFT = 0;
    localparam int EDGE_TOP = 1;
    localparam int EDGE_RIGHT = 2;
    localparam int EDGE_BOTTOM = 3;
    typedef enum logic [2:0] {IDLE, COUNT, DECIDE, DROP, HALT} fleet_state_t;
endpackage

// File: rtl/fleet_step_scheduler_if.sv
// fleet_step_scheduler_if: frame/edge/collision inputs and step command outputs of the fleet scheduler.
interface fleet_step_scheduler_if;
    import fleet_pkg::*;
    logic startOfFrame;
    logic enable;
    logic [3:0] HitEdgeCode;
    logic collision;
    logic moveStrobe;
    logic toggleX;
    logic stepDown;
    logic dirRight;
    logic [PERIOD_W-1:0] periodFrames;
    logic fleetLanded;
    logic waveCleared;
    modport master(
        output startOfFrame, enable, HitEdgeCode, collision,
        input moveStrobe, toggleX, stepDown, dirRight, periodFrames, fleetLanded, waveCleared
    );
    modport slave(
        input startOfFrame, enable, HitEdgeCode, collision,
        output moveStrobe, toggleX, stepDown, dirRight, periodFrames, fleetLanded, waveCleared
    );
endinterface

// File: rtl/fleet_speed_ctrl.sv
// fleet_speed_ctrl: counts kills on collision rising edges, shortens the step period and flags a cleared wave.
module fleet_speed_ctrl
    import fleet_pkg::*;
#(
    parameter int INIT_PERIOD = 32,
    parameter int MIN_PERIOD = 2,
    parameter int KILLS_PER_SPEEDUP = 4,
    parameter int TOTAL_INVADERS = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic collision,
    input  logic halted,
    output logic [PERIOD_W-1:0] periodFrames,
    output logic waveCleared
);
    logic collPrev;
    logic [7:0] killCnt;
    logic [7:0] subCnt;
    logic kill;
    logic lastKill;
    logic speedup;

    assign kill = collision && !collPrev && !halted;
    assign lastKill = killCnt >= 8'(TOTAL_INVADERS - 1);
    assign speedup = subCnt == 8'(KILLS_PER_SPEEDUP - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collPrev <= 1'b0;
            killCnt <= '0;
            subCnt <= '0;
            periodFrames <= PERIOD_W'(INIT_PERIOD);
            waveCleared <= 1'b0;
        end else begin
            collPrev <= collision;
            if (kill) begin
                killCnt <= lastKill ? 8'(TOTAL_INVADERS) : killCnt + 8'd1;
                waveCleared <= waveCleared | lastKill;
                subCnt <= speedup ? '0 : subCnt + 8'd1;
                if (speedup && periodFrames > PERIOD_W'(MIN_PERIOD))
                    periodFrames <= periodFrames - PERIOD_W'(1);
            end
        end
    end
endmodule

// File: rtl/fleet_step_scheduler.sv
// fleet_step_scheduler: per-frame sequencer deciding fleet move, reverse/drop and halt from latched edge hits.
module fleet_step_scheduler
    import fleet_pkg::*;
#(
    parameter int INIT_PERIOD = 32,
    parameter int MIN_PERIOD = 2,
    parameter int KILLS_PER_SPEEDUP = 4,
    parameter int TOTAL_INVADERS = 32
) (
    input logic clk,
    input logic reset,
    fleet_step_scheduler_if.slave bus
);
    fleet_state_t state;
    logic [PERIOD_W-1:0] frameCnt;
    logic [PERIOD_W-1:0] periodFrames;
    logic [3:0] edgeLatch;
    logic moveStrobe, toggleX, stepDown, dirRight, fleetLanded, waveCleared;
    logic dirEdge;

    fleet_speed_ctrl #(
        .INIT_PERIOD(INIT_PERIOD),
        .MIN_PERIOD(MIN_PERIOD),
        .KILLS_PER_SPEEDUP(KILLS_PER_SPEEDUP),
        .TOTAL_INVADERS(TOTAL_INVADERS)
    ) uSpeed (
        .clk(clk),
        .reset(reset),
        .collision(bus.collision),
        .halted(state == HALT),
        .periodFrames(periodFrames),
        .waveCleared(waveCleared)
    );

    // Only the edge in the direction of travel forces a reversal.
    assign dirEdge = dirRight ? edgeLatch[EDGE_RIGHT] : edgeLatch[EDGE_LEFT];

    assign bus.moveStrobe = moveStrobe;
    assign bus.toggleX = toggleX;
    assign bus.stepDown = stepDown;
    assign bus.dirRight = dirRight;
    assign bus.periodFrames = periodFrames;
    assign bus.fleetLanded = fleetLanded;
    assign bus.waveCleared = waveCleared;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            frameCnt <= '0;
            edgeLatch <= '0;
            dirRight <= 1'b1;
            moveStrobe <= 1'b0;
            toggleX <= 1'b0;
            stepDown <= 1'b0;
            fleetLanded <= 1'b0;
        end else begin
            moveStrobe <= 1'b0;
            toggleX <= 1'b0;
            stepDown <= 1'b0;
            if (state != HALT && !bus.enable) begin
                state <= IDLE;
                frameCnt <= '0;
                edgeLatch <= '0;
            end else begin
                case (state)
                    IDLE: state <= COUNT;
                    COUNT: begin
                        edgeLatch <= edgeLatch | bus.HitEdgeCode;
                        // >= so a period shortened mid-interval fires on the very next frame
                        if (bus.startOfFrame) begin
                            if (frameCnt >= periodFrames - PERIOD_W'(1)) begin
                                frameCnt <= '0;
                                state <= DECIDE;
                            end else begin
                                frameCnt <= frameCnt + PERIOD_W'(1);
                            end
                        end
                    end
                    DECIDE: begin
                        edgeLatch <= bus.HitEdgeCode;
                        if (edgeLatch[EDGE_BOTTOM]) begin
                            fleetLanded <= 1'b1;
                            state <= HALT;
                        end else if (waveCleared) begin
                            state <= HALT;
                        end else if (dirEdge) begin
                            toggleX <= 1'b1;
                            stepDown <= 1'b1;
                            state <= DROP;
                        end else begin
                            moveStrobe <= 1'b1;
                            state <= COUNT;
                        end
                    end
                    DROP: begin
                        dirRight <= !dirRight;
                        state <= COUNT;
                    end
                    default: state <= HALT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fleet_step_scheduler.sv
// tb_fleet_step_scheduler: randomized directed sequence checked against a frame-level reference model.
module tb_fleet_step_scheduler;
    import fleet_pkg::*;
    localparam int INIT = 4;
    localparam int MINP = 2;
    localparam int KPS = 4;
    localparam int TOTAL = 32;

    logic clk = 1'b0;
    logic reset;
    fleet_step_scheduler_if bus();

    fleet_step_scheduler #(
        .INIT_PERIOD(INIT),
        .MIN_PERIOD(MINP),
        .KILLS_PER_SPEEDUP(KPS),
        .TOTAL_INVADERS(TOTAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails = 0;
    int frames, kills;
    logic [3:0] edgeAcc;
    logic dir, landed, halted;
    bit st;

    function automatic int expPeriod();
        int p = INIT - kills / KPS;
        return p < MINP ? MINP : p;
    endfunction

    function automatic logic expCleared();
        return kills >= TOTAL;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        frames = 0; kills = 0; edgeAcc = '0;
        dir = 1'b1; landed = 1'b0; halted = 1'b0;
    endtask

    task automatic checkPulses(input string tag, input logic m, input logic t, input logic s);
        chk({tag, ".moveStrobe"}, 8'(bus.moveStrobe), 8'(m));
        chk({tag, ".toggleX"}, 8'(bus.toggleX), 8'(t));
        chk({tag, ".stepDown"}, 8'(bus.stepDown), 8'(s));
    endtask

    task automatic checkLevels(input string tag);
        chk({tag, ".dirRight"}, 8'(bus.dirRight), 8'(dir));
        chk({tag, ".fleetLanded"}, 8'(bus.fleetLanded), 8'(landed));
        chk({tag, ".waveCleared"}, 8'(bus.waveCleared), 8'(expCleared()));
        chk({tag, ".periodFrames"}, 8'(bus.periodFrames), 8'(expPeriod()));
    endtask

    task automatic hit(input logic [3:0] code);
        bus.HitEdgeCode = code;
        cyc();
        bus.HitEdgeCode = '0;
        edgeAcc |= code;
    endtask

    task automatic sof(output bit stepped);
        logic m, t, s;
        bus.startOfFrame = 1'b1;
        cyc();
        bus.startOfFrame = 1'b0;
        checkPulses("sof", 0, 0, 0);
        stepped = halted || frames >= expPeriod() - 1;
        if (halted || !stepped) begin
            if (!stepped) frames++;
            return;
        end
        frames = 0;
        m = 0; t = 0; s = 0;
        if (edgeAcc[EDGE_BOTTOM]) begin
            landed = 1'b1;
            halted = 1'b1;
        end else if (expCleared()) begin
            halted = 1'b1;
        end else if (dir ? edgeAcc[EDGE_RIGHT] : edgeAcc[EDGE_LEFT]) begin
            t = 1; s = 1;
        end else begin
            m = 1;
        end
        edgeAcc = '0;
        cyc();
        checkPulses("step", m, t, s);
        checkLevels("step");
        if (t) dir = !dir;
        cyc();
        checkPulses("stepAfter", 0, 0, 0);
        checkLevels("stepAfter");
    endtask

    task automatic interval(input logic [3:0] code);
        bit done = 0;
        repeat ($urandom_range(0, 2)) cyc();
        if (code != 0) hit(code);
        while (!done) begin
            repeat ($urandom_range(0, 2)) cyc();
            sof(done);
        end
    endtask

    task automatic kill();
        bus.collision = 1'b1;
        cyc();
        if (!halted) kills++;
        checkLevels("kill");
        bus.collision = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        bus.startOfFrame = 0; bus.enable = 0; bus.HitEdgeCode = '0; bus.collision = 0;
        modelReset();
        repeat (2) cyc();
        checkPulses("reset", 0, 0, 0);
        checkLevels("reset");
        reset = 1'b0;
        cyc();
        checkLevels("postReset");
        bus.enable = 1'b1;
        repeat (2) cyc();

        interval(4'b0000);
        interval(4'b0000);
        interval(4'b0100);
        interval(4'b0001);
        interval(4'b0001);
        interval(4'b0010);
        interval(4'b0100);
        interval(4'b0100);
        interval(4'b0001);

        for (int g = 0; g < 3; g++) begin
            repeat ($urandom_range(0, 3)) sof(st);
            repeat (4) kill();
        end
        interval(4'b0000);
        bus.collision = 1'b1;
        cyc();
        kills++;
        checkLevels("heldRise");
        repeat (99) cyc();
        bus.collision = 1'b0;
        cyc();
        checkLevels("heldFall");
        interval(4'b0000);

        sof(st);
        hit(4'b0100);
        bus.startOfFrame = 1'b1;
        bus.enable = 1'b0;
        cyc();
        bus.startOfFrame = 1'b0;
        frames = 0; edgeAcc = '0;
        checkPulses("disable", 0, 0, 0);
        cyc();
        checkPulses("disable2", 0, 0, 0);
        checkLevels("disable");
        bus.enable = 1'b1;
        repeat (2) cyc();
        interval(4'b0000);

        interval(4'b1100);
        repeat (10) begin
            repeat ($urandom_range(0, 2)) cyc();
            sof(st);
            checkLevels("landedHalt");
        end
        hit(4'b0101);
        kill();

        @(posedge clk);
        #3 reset = 1'b1;
        #1 modelReset();
        checkPulses("asyncReset", 0, 0, 0);
        checkLevels("asyncReset");
        cyc();
        reset = 1'b0;
        repeat (2) cyc();

        for (int k = 0; k < TOTAL; k++) begin
            if ($urandom_range(0, 3) == 0) sof(st);
            kill();
        end
        interval(4'b0000);
        repeat (3) begin
            sof(st);
            checkLevels("clearedHalt");
        end

        @(posedge clk);
        #4 reset = 1'b1;
        #1 modelReset();
        checkPulses("finalReset", 0, 0, 0);
        checkLevels("finalReset");
        cyc();
        reset = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule

// File: doc/fleet_step_scheduler.md
# fleet_step_scheduler

Per-frame sequencer for the invader fleet mover. Decides on which frames the fleet advances, when it reverses and drops a row, and how fast it marches as invaders are destroyed. Sits between the frame timing generator and the fleet move/collision block. Drives that block's gated frame strobe, X-toggle and row-drop commands from the edge-hit code returned by the fleet bitmap.

## Interface
- INIT_PERIOD, 32: frames between fleet steps at wave start (2..63).
- MIN_PERIOD, 2: fastest step period in frames (1..INIT_PERIOD).
- KILLS_PER_SPEEDUP, 4: kills that shorten the period by one frame.
- TOTAL_INVADERS, 32: kills that clear the wave (1..255).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- startOfFrame  in  1  one-cycle pulse per video frame.
- enable  in  1  level; game running.
- HitEdgeCode  in  4  fleet edge flags: [0]=left, [1]=top, [2]=right, [3]=bottom.
- collision  in  1  level; invader hit by missile.
- moveStrobe  out  1  one-cycle pulse; the fleet moves one step.
- toggleX  out  1  one-cycle pulse; reverse X direction.
- stepDown  out  1  one-cycle pulse; drop fleet one row.
- dirRight  out  1  level; current march direction (1 = right).
- periodFrames  out  6  current step period.
- fleetLanded  out  1  sticky; fleet reached the bottom.
- waveCleared  out  1  sticky; all invaders destroyed.

## Operation
- States: IDLE, COUNT, DECIDE, DROP, HALT.
- IDLE: entered from reset or when enable=0, from any non-HALT state.
  - frameCnt=0, edgeLatch=0.
  - Go to COUNT when enable=1.
- COUNT: each startOfFrame increments frameCnt.
  - When startOfFrame arrives with frameCnt==periodFrames-1: frameCnt←0 and go to DECIDE.
- edgeLatch[3:0] ORs in HitEdgeCode every cycle in COUNT and DECIDE.
  - It clears in the DECIDE cycle.
  - A bit asserted during the DECIDE cycle itself survives into the next step interval.
- DECIDE (one cycle). Priority, highest first:
  1. edgeLatch[3] → set fleetLanded, go to HALT. No other pulses.
  2. waveCleared → go to HALT.
  3. Direction-relevant edge (edgeLatch[2] while dirRight=1, or edgeLatch[0] while dirRight=0) → go to DROP.
  4. Otherwise → pulse moveStrobe, return to COUNT.
- The opposite-side edge and the top edge are ignored.
- DROP (one cycle): pulse toggleX and stepDown together, invert dirRight, return to COUNT. No moveStrobe on a drop step.
- HALT: all pulses low; the sticky flags hold. Only reset exits HALT.
- Kill counting:
  - A kill is a collision rising edge (registered previous value), counted in any state except HALT.
  - killCnt is 8 bits and saturates at TOTAL_INVADERS; reaching it sets waveCleared.
  - A sub-counter wraps at KILLS_PER_SPEEDUP. On each wrap, periodFrames decrements by 1, floored at MIN_PERIOD.
- The period change takes effect at the next frameCnt comparison. If frameCnt ≥ new period-1, the next startOfFrame triggers DECIDE.

## Timing
- Reset values:
  - state=IDLE, dirRight=1, periodFrames=INIT_PERIOD.
  - moveStrobe=toggleX=stepDown=0, fleetLanded=waveCleared=0.
  - killCnt=0, edgeLatch=0.
- All outputs are registered.
- Step latency: triggering startOfFrame in cycle t → DECIDE in t+1.
  - moveStrobe high in t+2 on a normal step.
  - Drop step: toggleX/stepDown high in t+2, dirRight flips in t+3.
  - fleetLanded high in t+2 on a landing step.
- Kill latency: collision rising edge in cycle t → killCnt updated in t+1; periodFrames/waveCleared updated in t+1.
- Simultaneous startOfFrame and enable falling: enable wins, go to IDLE, no step.
- Collision held high counts once.
- Reset asserted mid-operation: all state returns to reset values asynchronously; pulses drop immediately.

## Structure
- Shared package fleet_pkg holds:
  - state enum fleet_state_t.
  - HitEdgeCode bit index constants EDGE_LEFT/TOP/RIGHT/BOTTOM, shared with the bitmap block.
  - Period width constant (6).
- One natural sub-module: fleet_speed_ctrl, covering kill edge detect, the two kill counters, periodFrames and waveCleared.
- The FSM, frame counter and edge latch stay in the top module.

## Test plan
- Reset, enable=1, INIT_PERIOD=4, no edges → moveStrobe pulses once every 4 startOfFrame pulses, 2 cycles after the 4th; dirRight=1.
- HitEdgeCode=4'b0100 pulsed one cycle mid-interval with dirRight=1 → at the next step: toggleX and stepDown high in the same cycle, no moveStrobe, dirRight=0 after. A later left-edge pulse → drop again, dirRight=1.
- HitEdgeCode=4'b0001 while dirRight=1 → ignored, normal moveStrobe.
- 8 collision rising edges (KILLS_PER_SPEEDUP=4, INIT_PERIOD=4, MIN_PERIOD=2) → periodFrames 4→3→2. A further 4 kills keep it at 2. A collision held for 100 cycles counts 1.
- HitEdgeCode=4'b1100 latched, dirRight=1 → fleetLanded=1, no toggleX/stepDown. All pulses stay low for 10 further frames.
- 32 kills → waveCleared=1, HALT at the next DECIDE. Reset pulse mid-interval → all outputs return to reset values within the reset cycle.
